// File: rtl/counter.sv
// Two-bit up/down counter with selectable modulo-4 or modulo-3 wrap.
// The count is held in a register; outputs are taken straight from it.
module counter (
   input  logic clock,
   input  logic reset,
   input  logic s0,
   input  logic s1,
   output logic q0,
   output logic q1
);

   typedef enum logic [1:0] {
      MODE_UP4 = 2'b00,
      MODE_DN4 = 2'b01,
      MODE_UP3 = 2'b10,
      MODE_DN3 = 2'b11
   } mode_e;

   mode_e      mode;
   logic [1:0] count_q;
   logic [1:0] count_d;

   assign mode = mode_e'({s1, s0});

   // Modulo-3 modes fold the unused code 11 back into the 0..2 cycle.
   always_comb begin
      count_d = count_q;
      case (mode)
         MODE_UP4: count_d = count_q + 2'd1;
         MODE_DN4: count_d = count_q - 2'd1;
         MODE_UP3: count_d = (count_q >= 2'd2) ? 2'd0 : count_q + 2'd1;
         MODE_DN3: count_d = (count_q == 2'd0 || count_q == 2'd3) ? 2'd2
                                                                  : count_q - 2'd1;
         default:  count_d = 2'd0;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count_q <= 2'd0;
      end else begin
         count_q <= count_d;
      end
   end

   assign q0 = count_q[0];
   assign q1 = count_q[1];

endmodule

// File: tb/tb_counter.sv
// Directed and randomized checks of the 2-bit modulo-4/modulo-3 counter
// against a behavioural model using modular arithmetic.
module tb_counter;

   logic clk;
   logic reset;
   logic s0;
   logic s1;
   logic q0;
   logic q1;

   int tests;
   int fails;
   int exp_count;
   bit cmp_en;

   counter dut (
      .clock (clk),
      .reset (reset),
      .s0    (s0),
      .s1    (s1),
      .q0    (q0),
      .q1    (q1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Next count from the mode rules: modulus 4 or 3, step +1 or -1.
   function automatic int model_next(input int c, input bit m1, input bit m0);
      int modulus;
      modulus = m1 ? 3 : 4;
      if (m1 && c == 3) return m0 ? 2 : 0;
      if (m0) return (c + modulus - 1) % modulus;
      return (c + 1) % modulus;
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) exp_count <= 0;
      else       exp_count <= model_next(exp_count, s1, s0);
   end

   task automatic check(input string name, input int actual, input int expected);
      tests++;
      if (actual !== expected) begin
         fails++;
         $display("FAIL %s: got %0d, required %0d", name, actual, expected);
      end
   endtask

   // Continuous comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (cmp_en) check("model", int'({q1, q0}), exp_count);
   end

   // One edge, then compare against a hand-computed literal.
   task automatic step(input string name, input int expected);
      @(posedge clk);
      #1;
      $display("[TB] %s mode=%b%b count=%b%b expect=%0d", name, s1, s0, q1, q0, expected);
      check(name, int'({q1, q0}), expected);
   endtask

   initial begin
      tests  = 0;
      fails  = 0;
      cmp_en = 1'b0;
      reset  = 1'b1;
      s0     = 1'b0;
      s1     = 1'b0;
      #12;
      check("reset_state", int'({q1, q0}), 0);
      @(negedge clk);
      check("reset_held", int'({q1, q0}), 0);
      reset  = 1'b0;
      cmp_en = 1'b1;

      // Modulo-4 up.
      {s1, s0} = 2'b00;
      step("up4_1", 1); step("up4_2", 2); step("up4_3", 3); step("up4_4", 0);
      // Modulo-4 down from 00.
      {s1, s0} = 2'b01;
      step("dn4_1", 3); step("dn4_2", 2); step("dn4_3", 1); step("dn4_4", 0);
      step("dn4_5", 3);
      // Modulo-3 up from out-of-range 11.
      {s1, s0} = 2'b10;
      step("up3_1", 0); step("up3_2", 1); step("up3_3", 2); step("up3_4", 0);
      step("up3_5", 1);
      // Modulo-3 down from 01.
      {s1, s0} = 2'b11;
      step("dn3_1", 0); step("dn3_2", 2); step("dn3_3", 1); step("dn3_4", 0);
      step("dn3_5", 2);
      // Reach 11 in modulo-4 up, then modulo-3 down folds it to 10.
      {s1, s0} = 2'b00;
      step("to11", 3);
      {s1, s0} = 2'b11;
      step("dn3_from11", 2);

      // Asynchronous reset between edges at count 10.
      #2;
      reset = 1'b1;
      #1;
      check("async_clear", int'({q1, q0}), 0);
      repeat (3) begin
         @(posedge clk);
         #1;
         check("reset_hold", int'({q1, q0}), 0);
      end
      #2;
      reset = 1'b0;
      {s1, s0} = 2'b01;
      step("first_after_reset", 3);

      // Randomized modes with occasional mid-cycle reset pulses.
      for (int i = 0; i < 2000; i++) begin
         @(posedge clk);
         #1;
         {s1, s0} = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 40) == 0) begin
            reset = 1'b1;
            #1;
            check("rand_async_clear", int'({q1, q0}), 0);
            #1;
            reset = 1'b0;
         end
      end

      @(negedge clk);
      #1;
      cmp_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
